// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one bit per cycle over XLEN cycles.
// Divide-by-zero and signed overflow results are produced directly at accept.
module muldiv_unit #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned TAG_W = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       op,
   input  logic [XLEN-1:0]  a,
   input  logic [XLEN-1:0]  b,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  result,
   output logic [TAG_W-1:0] out_tag
);

   localparam int unsigned CNT_W = $clog2(XLEN);
   localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

   localparam logic [2:0] OP_MULH   = 3'b001;
   localparam logic [2:0] OP_MULHSU = 3'b010;
   localparam logic [2:0] OP_DIV    = 3'b100;
   localparam logic [2:0] OP_REM    = 3'b110;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t            state, state_nx;
   logic              accept, finish;

   logic [2:0]        op_q;
   logic [TAG_W-1:0]  tag_q;
   logic [CNT_W-1:0]  cnt;
   logic [2*XLEN-1:0] prod;
   logic [XLEN-1:0]   mcand;
   logic              neg_q;
   logic [XLEN-1:0]   result_q;

   // Operand decoding at accept time
   logic              a_sgn, b_sgn, is_div, div_zero, ovf, special, neg_acc;
   logic [XLEN-1:0]   a_mag, b_mag, special_res;

   always_comb begin
      a_sgn    = ((op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM)) & a[XLEN-1];
      b_sgn    = ((op == OP_MULH) || (op == OP_DIV) || (op == OP_REM)) & b[XLEN-1];
      a_mag    = a_sgn ? -a : a;
      b_mag    = b_sgn ? -b : b;
      is_div   = op[2];
      div_zero = is_div && (b == '0);
      ovf      = is_div && !op[0] && (a == MIN_NEG) && (b == '1);
      special  = div_zero || ovf;
      if (div_zero)
         special_res = op[1] ? a : '1;
      else
         special_res = op[1] ? '0 : a;
      // Remainder follows the dividend sign; quotient and products follow the sign product
      neg_acc  = (is_div && op[1]) ? a_sgn : (a_sgn ^ b_sgn);
   end

   // One iteration: shift-add multiply or restoring divide on the shared product register
   logic [XLEN:0]     sum, rem_sh, diff;
   logic [2*XLEN-1:0] mul_nx, div_nx, prod_nx, mul_full;
   logic [XLEN-1:0]   div_val, div_res, fin_res;

   always_comb begin
      sum     = {1'b0, prod[2*XLEN-1:XLEN]} + {1'b0, mcand & {XLEN{prod[0]}}};
      mul_nx  = {sum, prod[XLEN-1:1]};
      rem_sh  = {prod[2*XLEN-1:XLEN], prod[XLEN-1]};
      diff    = rem_sh - {1'b0, mcand};
      div_nx  = diff[XLEN] ? {rem_sh[XLEN-1:0], prod[XLEN-2:0], 1'b0}
                           : {diff[XLEN-1:0],   prod[XLEN-2:0], 1'b1};
      prod_nx = op_q[2] ? div_nx : mul_nx;

      mul_full = neg_q ? -prod_nx : prod_nx;
      div_val  = op_q[1] ? prod_nx[2*XLEN-1:XLEN] : prod_nx[XLEN-1:0];
      div_res  = neg_q ? -div_val : div_val;
      if (op_q[2])
         fin_res = div_res;
      else if (op_q[1:0] == 2'b00)
         fin_res = mul_full[XLEN-1:0];
      else
         fin_res = mul_full[2*XLEN-1:XLEN];
   end

   always_comb begin
      state_nx = state;
      accept   = 1'b0;
      finish   = 1'b0;
      case (state)
         IDLE: begin
            if (in_valid && !flush) begin
               accept   = 1'b1;
               state_nx = special ? DONE : BUSY;
            end
         end
         BUSY: begin
            if (cnt == CNT_W'(XLEN-1)) begin
               finish   = 1'b1;
               state_nx = DONE;
            end
         end
         DONE: begin
            if (out_ready)
               state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
      if (flush)
         state_nx = IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_nx;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q     <= '0;
         tag_q    <= '0;
         cnt      <= '0;
         prod     <= '0;
         mcand    <= '0;
         neg_q    <= 1'b0;
         result_q <= '0;
      end else if (accept) begin
         op_q     <= op;
         tag_q    <= in_tag;
         cnt      <= '0;
         neg_q    <= neg_acc;
         result_q <= special_res;
         // Multiplier (mul) or dividend (div) enters the low half; the other operand is held
         prod     <= {{XLEN{1'b0}}, is_div ? a_mag : b_mag};
         mcand    <= is_div ? b_mag : a_mag;
      end else if (state == BUSY) begin
         prod <= prod_nx;
         cnt  <= cnt + CNT_W'(1);
         if (finish)
            result_q <= fin_res;
      end
   end

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign result    = out_valid ? result_q : '0;
   assign out_tag   = out_valid ? tag_q : '0;

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized self-checking bench for muldiv_unit (XLEN=32) against an
// arithmetic reference model; a single compare process checks every cycle.
module tb_muldiv_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  op;
   logic [31:0] a, b;
   logic [4:0]  in_tag;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic [4:0]  out_tag;

   muldiv_unit #(.XLEN(32), .TAG_W(5)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .op(op), .a(a), .b(b),
      .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .out_tag(out_tag)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] res;
      logic [4:0]  tag;
      int          lat;
      int          acc;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   rdy_mode = 2;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, expv, $time);
      end
   endtask

   function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
      longint      sx, sy, ly;
      logic [63:0] p;
      int          ix, iy;
      sx = longint'(signed'(x));
      sy = longint'(signed'(y));
      ly = longint'({32'b0, y});
      ix = x;
      iy = y;
      case (o)
         3'd0: begin p = sx * sy; return p[31:0]; end
         3'd1: begin p = sx * sy; return p[63:32]; end
         3'd2: begin p = sx * ly; return p[63:32]; end
         3'd3: begin p = {32'b0, x} * {32'b0, y}; return p[63:32]; end
         3'd4: begin
            if (y == 0) return 32'hFFFFFFFF;
            if (x == 32'h80000000 && y == 32'hFFFFFFFF) return x;
            return ix / iy;
         end
         3'd5: return (y == 0) ? 32'hFFFFFFFF : x / y;
         3'd6: begin
            if (y == 0) return x;
            if (x == 32'h80000000 && y == 32'hFFFFFFFF) return 32'h0;
            return ix % iy;
         end
         default: return (y == 0) ? x : x % y;
      endcase
   endfunction

   function automatic int model_lat(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
      if (o[2] && (y == 0 || (!o[0] && x == 32'h80000000 && y == 32'hFFFFFFFF)))
         return 1;
      return 33;
   endfunction

   // Compare process: outputs sampled on the falling edge
   logic prev_valid = 1'b0;
   logic prev_hs = 1'b0;
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         if (out_valid) begin
            if (exp_q.size() == 0) begin
               chk("spurious_out_valid", 64'(out_valid), 64'd0);
            end else begin
               chk("result", 64'(result), 64'(exp_q[0].res));
               chk("out_tag", 64'(out_tag), 64'(exp_q[0].tag));
               chk("in_ready_in_done", 64'(in_ready), 64'd0);
               if (!prev_valid)
                  chk("latency", 64'(cyc - exp_q[0].acc), 64'(exp_q[0].lat));
               if (out_ready)
                  void'(exp_q.pop_front());
            end
         end else begin
            chk("idle_result_zero", {27'b0, out_tag, result}, 64'd0);
         end
         if (prev_hs)
            chk("in_ready_after_handshake", 64'(in_ready), 64'd1);
         prev_hs    = out_valid && out_ready && !flush;
         prev_valid = out_valid;
      end else begin
         prev_hs    = 1'b0;
         prev_valid = 1'b0;
      end
   end

   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #2;
         case (rdy_mode)
            0:       out_ready = ($urandom % 4) != 0;
            1:       out_ready = 1'b0;
            default: out_ready = 1'b1;
         endcase
      end
   end

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic send(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, input logic [4:0] t);
      exp_t e;
      int w = 0;
      while (!in_ready && w < 200) begin
         step(1);
         w++;
      end
      if (!in_ready) begin
         chk("in_ready_timeout", 64'(in_ready), 64'd1);
      end else begin
         op = o; a = x; b = y; in_tag = t; in_valid = 1'b1;
         e.res = model(o, x, y);
         e.tag = t;
         e.lat = model_lat(o, x, y);
         e.acc = cyc;
         exp_q.push_back(e);
         step(1);
         in_valid = 1'b0;
         a = $urandom; b = $urandom; op = 3'($urandom); in_tag = 5'($urandom);
      end
   endtask

   task automatic drain();
      int w = 0;
      while (exp_q.size() != 0 && w < 300) begin
         step(1);
         w++;
      end
      chk("drain_timeout", 64'(exp_q.size()), 64'd0);
   endtask

   function automatic logic [31:0] pick();
      case ($urandom % 8)
         0: return 32'h0;
         1: return 32'hFFFFFFFF;
         2: return 32'h80000000;
         3: return 32'h1;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog_timeout actual=running expected=finished");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0;
      op = '0; a = '0; b = '0; in_tag = '0;
      #3;
      // Reset state before any clock edge
      chk("reset_in_ready", 64'(in_ready), 64'd1);
      chk("reset_out_valid", 64'(out_valid), 64'd0);
      chk("reset_outputs", {27'b0, out_tag, result}, 64'd0);

      // Pin the model with hand-computed values
      chk("model_mul", 64'(model(3'd0, 32'd7, 32'hFFFFFFFD)), 64'hFFFFFFEB);
      chk("model_mulhu", 64'(model(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF)), 64'hFFFFFFFE);
      chk("model_mulh", 64'(model(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF)), 64'h0);
      chk("model_mulhsu", 64'(model(3'd2, 32'hFFFFFFFF, 32'd2)), 64'hFFFFFFFF);
      chk("model_div", 64'(model(3'd4, 32'hFFFFFFF9, 32'd2)), 64'hFFFFFFFD);
      chk("model_rem", 64'(model(3'd6, 32'hFFFFFFF9, 32'd2)), 64'hFFFFFFFF);
      chk("model_divu", 64'(model(3'd5, 32'h80000000, 32'd3)), 64'h2AAAAAAA);
      chk("model_div0", 64'(model(3'd4, 32'd5, 32'd0)), 64'hFFFFFFFF);
      chk("model_remu0", 64'(model(3'd7, 32'd5, 32'd0)), 64'd5);
      chk("model_divovf", 64'(model(3'd4, 32'h80000000, 32'hFFFFFFFF)), 64'h80000000);
      chk("model_removf", 64'(model(3'd6, 32'h80000000, 32'hFFFFFFFF)), 64'h0);
      chk("model_mul34", 64'(model(3'd0, 32'd3, 32'd4)), 64'd12);

      step(2);
      rst_n = 1'b1;
      step(2);

      // Directed operations
      send(3'd0, 32'd7, 32'hFFFFFFFD, 5'd4);            drain();
      send(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd1);     drain();
      send(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2);     drain();
      send(3'd2, 32'hFFFFFFFF, 32'd2, 5'd3);            drain();
      send(3'd4, 32'hFFFFFFF9, 32'd2, 5'd5);            drain();
      send(3'd6, 32'hFFFFFFF9, 32'd2, 5'd6);            drain();
      send(3'd5, 32'h80000000, 32'd3, 5'd7);            drain();
      send(3'd4, 32'd5, 32'd0, 5'd8);                   drain();
      send(3'd7, 32'd5, 32'd0, 5'd9);                   drain();
      send(3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd10);    drain();
      send(3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd11);    drain();

      // Consumer stalls for 10 cycles in DONE
      rdy_mode = 1;
      step(1);
      send(3'd4, 32'd1000, 32'd7, 5'd12);
      for (int w = 0; w < 100 && !out_valid; w++) step(1);
      chk("stall_reached_done", 64'(out_valid), 64'd1);
      step(10);
      chk("stall_still_valid", 64'(out_valid), 64'd1);
      rdy_mode = 2;
      drain();

      // Flush on BUSY cycle 10
      send(3'd5, 32'hDEADBEEF, 32'd13, 5'd13);
      step(9);
      flush = 1'b1;
      step(1);
      flush = 1'b0;
      exp_q.delete();
      step(1);
      chk("flush_in_ready", 64'(in_ready), 64'd1);
      step(40);

      // Reset on BUSY cycle 20
      send(3'd1, 32'h12345678, 32'h9ABCDEF0, 5'd14);
      step(19);
      rst_n = 1'b0;
      #1;
      chk("midreset_in_ready", 64'(in_ready), 64'd1);
      chk("midreset_outputs", {26'b0, out_valid, out_tag, result}, 64'd0);
      exp_q.delete();
      step(3);
      rst_n = 1'b1;
      step(40);
      send(3'd0, 32'd3, 32'd4, 5'd15);                  drain();

      // Randomized traffic with random back-pressure
      rdy_mode = 0;
      for (int i = 0; i < 300; i++)
         send(3'($urandom), pick(), pick(), 5'($urandom));
      rdy_mode = 2;
      drain();
      step(5);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL take parameter XLEN, default 32: operand and result width, any even value from 8 to 64.
REQ-002 SHALL take parameter TAG_W, default 5: width of the opaque tag (ROB index) carried with each operation.
REQ-003 SHALL have port clk, input, 1: sole clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port flush, input, 1: synchronous abort of any operation in flight.
REQ-006 SHALL have port in_valid, input, 1: operation request.
REQ-007 SHALL have port in_ready, output, 1: unit can accept a request.
REQ-008 SHALL have port op, input, 3: RV32M funct3 (000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU).
REQ-009 SHALL have ports a and b, input, XLEN each: rs1 and rs2 operands.
REQ-010 SHALL have port in_tag, input, TAG_W: tag for the request.
REQ-011 SHALL have port out_valid, output, 1: result available.
REQ-012 SHALL have port out_ready, input, 1: consumer takes the result.
REQ-013 SHALL have port result, output, XLEN: operation result.
REQ-014 SHALL have port out_tag, output, TAG_W: tag of the returned result.

Function
REQ-015 SHALL have FSM states IDLE, BUSY, DONE; in_ready = 1 only in IDLE.
REQ-016 SHALL accept on in_valid & in_ready, latching op, a, b, in_tag.
REQ-017 SHALL, in the accept cycle, go IDLE -> BUSY for normal ops and IDLE -> DONE for special cases (REQ-022, REQ-023).
REQ-018 SHALL iterate exactly XLEN cycles in BUSY, one bit per cycle: multiply by shift-add on a 2*XLEN product; divide by restoring division on magnitudes.
REQ-019 SHALL go BUSY -> DONE after the XLEN-th iteration, so out_valid rises XLEN+1 cycles after the accept edge for normal ops and 1 cycle after for special cases.
REQ-020 SHALL, for multiply, return the low XLEN product bits for MUL and the high XLEN bits for MULH (s*s), MULHSU (s*u), MULHU (u*u).
REQ-021 SHALL, for signed divide, divide magnitudes, negate the quotient if the operand signs differ, and give the remainder the sign of the dividend.
REQ-022 SHALL, on divide by zero, return quotient all-ones (DIV, DIVU) and remainder = a (REM, REMU).
REQ-023 SHALL, on signed overflow (a = most negative, b = -1), return quotient = a for DIV and remainder 0 for REM.
REQ-024 SHALL, in DONE, hold out_valid = 1 and keep result and out_tag stable until out_ready; DONE -> IDLE on out_ready.
REQ-025 SHALL NOT accept a request in the same cycle as the DONE handshake; in_ready rises the following cycle.
REQ-026 SHALL, on flush in any state, return to IDLE next cycle and drop out_valid; flush beats a simultaneous accept or handshake, and no result for the flushed tag ever appears.
REQ-027 SHALL drive result and out_tag to 0 whenever out_valid = 0.

Reset
REQ-028 SHALL, while rst_n = 0, immediately and without waiting for a clock edge hold the FSM in IDLE, in_ready = 1, out_valid = 0, result = 0, out_tag = 0, and clear all datapath registers.
REQ-029 SHALL, if reset hits mid-operation, discard the operation and return no result after reset releases.

Verification
REQ-030 SHALL be verified by: MUL a=7, b=-3, tag=4 -> result 0xFFFFFFEB, out_tag 4, out_valid exactly 33 cycles after accept.
REQ-031 SHALL be verified by: MULHU a=b=0xFFFFFFFF -> 0xFFFFFFFE; MULH same operands -> 0x00000000; MULHSU a=-1, b=2 -> 0xFFFFFFFF.
REQ-032 SHALL be verified by: DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 0x80000000/3 -> 0x2AAAAAAA.
REQ-033 SHALL be verified by: DIV 5/0 -> 0xFFFFFFFF and REMU 5/0 -> 5, both 1 cycle after accept; DIV 0x80000000/-1 -> 0x80000000; REM same operands -> 0.
REQ-034 SHALL be verified by: out_ready held 0 for 10 cycles in DONE -> result stable, in_ready = 0 throughout; out_ready = 1 -> in_ready = 1 the next cycle.
REQ-035 SHALL be verified by: flush on BUSY cycle 10, and rst_n low on BUSY cycle 20 of another op -> IDLE, no out_valid, then a fresh MUL 3*4 returns 12.
